hdlc_tx_sequencer: RTL and testbench

Bit-level transmit controller for the HDLC Tx channel. It sequences the serial line through idle, start flag, buffered payload with zero insertion, optional FCS, end flag and abort pattern. It fetches payload bytes from the Tx buffer through a read-strobe handshake and drives Tx, Tx_ValidFrame, Tx_Done and Tx_AbortedTrans. It sits between the Tx buffer/register interface and the Tx pin.

---
 rtl/hdlc_tx_sequencer_if.sv | 23 ++
 rtl/hdlc_tx_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_hdlc_tx_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_tx_sequencer_if.sv
// Tx buffer / line-side signal bundle for hdlc_tx_sequencer.
// master = buffer/register side (drives requests), slave = sequencer.
interface hdlc_tx_sequencer_if;
  logic       Tx_Enable;
  logic       Tx_AbortFrame;
  logic [7:0] Tx_FrameSize;
  logic [7:0] Tx_DataOutBuff;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  modport master (
    output Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_DataOutBuff,
    input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );

  modport slave (
    input  Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_DataOutBuff,
    output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
endinterface

// File: rtl/hdlc_tx_sequencer.sv
// HDLC Tx bit sequencer: flags, zero-inserted payload, optional FCS, abort pattern.
// Define TX_FCS_EN to append a serial CRC-16 (0x8005, reflected) after the payload.
//
// state      | meaning
// IDLE       | line at IDLE_BIT, waiting for Tx_Enable with non-zero size
// START_FLAG | sending 0x7E, first payload byte fetched
// DATA       | shifting payload bytes with zero insertion
// FCS        | sending 16 CRC bits with zero insertion (TX_FCS_EN only)
// END_FLAG   | sending closing 0x7E
// ABORT      | sending 0 then seven 1s
module hdlc_tx_sequencer #(
  parameter int MAX_FRAME = 126,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  hdlc_tx_sequencer_if.slave   txIf
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_FLAG = 3'd1,
    DATA       = 3'd2,
    FCS        = 3'd3,
    END_FLAG   = 3'd4,
    ABORT      = 3'd5
  } state_t;

  localparam logic [7:0] FLAG        = 8'h7E;
  localparam logic [7:0] MAX_FRAME_B = 8'(MAX_FRAME);

  state_t     state, stateNext;
  logic [3:0] bitCnt;
  logic [7:0] byteCnt;
  logic [7:0] frameSize;
  logic [7:0] holdReg;
  logic [7:0] shiftReg;
  logic [2:0] onesCnt;
  logic       rdBuff;
  logic       rdPending;
  logic       lastLoaded;
  logic       txReg;

  logic       txBit;
  logic       validFrame;
  logic       doneFlag;
  logic       abortedPulse;
  logic       stuffBit;
  logic       byteEnd;
  logic       abortReq;
  logic       startReq;
  logic       lastByte;
  logic [7:0] sizeClamped;
  logic [7:0] byteCntInc;

`ifdef TX_FCS_EN
  logic [15:0] crcReg;
  logic [15:0] crcNext;
  logic        crcFb;
`endif

  assign stuffBit    = ((state == DATA) || (state == FCS)) && (onesCnt == 3'd5);
  assign byteEnd     = (state == DATA) && !stuffBit && (bitCnt == 4'd7);
  assign abortReq    = txIf.Tx_AbortFrame &&
                       ((state == START_FLAG) || (state == DATA) ||
                        (state == FCS) || (state == END_FLAG));
  assign startReq    = txIf.Tx_Enable && (txIf.Tx_FrameSize != 8'd0);
  assign sizeClamped = (txIf.Tx_FrameSize > MAX_FRAME_B) ? MAX_FRAME_B : txIf.Tx_FrameSize;
  assign byteCntInc  = byteCnt + 8'd1;
  assign lastByte    = (byteCntInc >= frameSize);

`ifdef TX_FCS_EN
  // Reflected form of 0x8005: shift right, feed back 0xA001.
  assign crcFb   = crcReg[0] ^ shiftReg[0];
  assign crcNext = {1'b0, crcReg[15:1]} ^ (crcFb ? 16'hA001 : 16'h0000);
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (startReq) stateNext = START_FLAG;
      end
      START_FLAG: begin
        if (bitCnt == 4'd7) stateNext = DATA;
      end
      DATA: begin
        if (byteEnd && (byteCnt >= frameSize)) begin
`ifdef TX_FCS_EN
          stateNext = FCS;
`else
          stateNext = END_FLAG;
`endif
        end
      end
`ifdef TX_FCS_EN
      FCS: begin
        if (!stuffBit && (bitCnt == 4'd15)) stateNext = END_FLAG;
      end
`endif
      END_FLAG: begin
        if (bitCnt == 4'd7) stateNext = IDLE;
      end
      ABORT: begin
        if (bitCnt == 4'd7) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Abort wins over whatever transition was chosen above.
    if (abortReq) stateNext = ABORT;
  end

  always_comb begin
    txBit        = IDLE_BIT;
    validFrame   = 1'b0;
    doneFlag     = 1'b1;
    abortedPulse = 1'b0;
    case (state)
      START_FLAG: begin
        txBit      = FLAG[bitCnt[2:0]];
        validFrame = 1'b1;
        doneFlag   = 1'b0;
      end
      DATA: begin
        txBit      = stuffBit ? 1'b0 : shiftReg[0];
        validFrame = 1'b1;
        doneFlag   = lastLoaded;
      end
`ifdef TX_FCS_EN
      FCS: begin
        txBit      = stuffBit ? 1'b0 : crcReg[0];
        validFrame = 1'b1;
        doneFlag   = lastLoaded;
      end
`endif
      END_FLAG: begin
        txBit      = FLAG[bitCnt[2:0]];
        validFrame = 1'b1;
      end
      ABORT: begin
        txBit        = (bitCnt != 4'd0);
        abortedPulse = (bitCnt == 4'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      bitCnt     <= 4'd0;
      byteCnt    <= 8'd0;
      frameSize  <= 8'd0;
      holdReg    <= 8'd0;
      shiftReg   <= 8'd0;
      onesCnt    <= 3'd0;
      rdBuff     <= 1'b0;
      rdPending  <= 1'b0;
      lastLoaded <= 1'b0;
      txReg      <= 1'b1;
`ifdef TX_FCS_EN
      crcReg     <= 16'h0000;
`endif
    end else begin
      txReg     <= txBit;
      rdBuff    <= 1'b0;
      rdPending <= rdBuff;
      if (rdPending) holdReg <= txIf.Tx_DataOutBuff;

      if ((stateNext != state) || byteEnd) begin
        bitCnt <= 4'd0;
      end else if ((state != IDLE) && !stuffBit) begin
        bitCnt <= bitCnt + 4'd1;
      end

      if ((state == DATA) || (state == FCS)) begin
        onesCnt <= txBit ? (onesCnt + 3'd1) : 3'd0;
      end else begin
        onesCnt <= 3'd0;
      end

      case (state)
        IDLE: begin
          if (stateNext == START_FLAG) begin
            frameSize  <= sizeClamped;
            byteCnt    <= 8'd0;
            lastLoaded <= 1'b0;
            rdBuff     <= 1'b1;
          end
        end
        START_FLAG, DATA: begin
          // Byte boundary: move the prefetched byte in and refill if more remain.
          if ((stateNext == DATA) && ((state == START_FLAG) || byteEnd)) begin
            shiftReg <= holdReg;
            byteCnt  <= byteCntInc;
            if (lastByte) lastLoaded <= 1'b1;
            else          rdBuff     <= 1'b1;
          end else if ((state == DATA) && !stuffBit) begin
            shiftReg <= {1'b0, shiftReg[7:1]};
          end
        end
        default: ;
      endcase

`ifdef TX_FCS_EN
      if (state == START_FLAG) begin
        crcReg <= 16'h0000;
      end else if ((state == DATA) && !stuffBit) begin
        crcReg <= crcNext;
      end else if ((state == FCS) && !stuffBit) begin
        crcReg <= {1'b0, crcReg[15:1]};
      end
`endif
    end
  end

  assign txIf.Tx              = txReg;
  assign txIf.Tx_RdBuff       = rdBuff;
  assign txIf.Tx_ValidFrame   = validFrame;
  assign txIf.Tx_Done         = doneFlag;
  assign txIf.Tx_AbortedTrans = abortedPulse;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Randomized bench for hdlc_tx_sequencer against a slot-stream reference model.
`timescale 1ns/1ps
module tb_hdlc_tx_sequencer;
  localparam int MAX_FRAME = 126;

  logic Clk = 1'b0;
  logic Rst;
  hdlc_tx_sequencer_if txIf();

  hdlc_tx_sequencer #(.MAX_FRAME(MAX_FRAME), .IDLE_BIT(1'b1)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .txIf (txIf)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;

  // Expected per-cycle line bit selection and strobes; index 0 is the accept cycle.
  bit selQ[$];
  bit validQ[$];
  bit doneQ[$];
  bit rdQ[$];
  bit abQ[$];
  logic [7:0] bufQ[$];
  bit obsTx[$];
  logic [7:0] flagByte = 8'h7E;

  task automatic checkEq(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] d[$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (d[i]) begin
      c = c ^ {8'h00, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic pushSlot(input bit s, input bit v, input bit d, input bit r, input bit a);
    selQ.push_back(s);
    validQ.push_back(v);
    doneQ.push_back(d);
    rdQ.push_back(r);
    abQ.push_back(a);
  endtask

  task automatic buildModel(input logic [7:0] sizeField, input logic [7:0] pay[$],
                            input int abortAt, output int lastValid);
    int n;
    int ones;
    bit first;
    bit b;
    logic [7:0] frameBytes[$];
    logic [15:0] crc;
    selQ.delete(); validQ.delete(); doneQ.delete(); rdQ.delete(); abQ.delete();
    n = (int'(sizeField) > MAX_FRAME) ? MAX_FRAME : int'(sizeField);
    pushSlot(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pushSlot(flagByte[i], 1'b1, 1'b0, (i == 0), 1'b0);
    ones = 0;
    for (int j = 0; j < n; j++) begin
      first = 1'b1;
      frameBytes.push_back(pay[j]);
      for (int i = 0; i < 8; i++) begin
        b = pay[j][i];
        if (ones == 5) begin
          pushSlot(1'b0, 1'b1, (j == n - 1), first && (j < n - 1), 1'b0);
          first = 1'b0;
          ones = 0;
        end
        pushSlot(b, 1'b1, (j == n - 1), first && (j < n - 1), 1'b0);
        first = 1'b0;
        ones = b ? ones + 1 : 0;
      end
    end
`ifdef TX_FCS_EN
    crc = crc16(frameBytes);
    for (int i = 0; i < 16; i++) begin
      b = crc[i];
      if (ones == 5) begin
        pushSlot(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ones = 0;
      end
      pushSlot(b, 1'b1, 1'b1, 1'b0, 1'b0);
      ones = b ? ones + 1 : 0;
    end
`else
    crc = 16'h0000;
`endif
    for (int i = 0; i < 8; i++) pushSlot(flagByte[i], 1'b1, 1'b1, 1'b0, 1'b0);
    lastValid = selQ.size() - 1;
    if (abortAt > 0) begin
      while (selQ.size() > abortAt + 1) begin
        void'(selQ.pop_back()); void'(validQ.pop_back()); void'(doneQ.pop_back());
        void'(rdQ.pop_back()); void'(abQ.pop_back());
      end
      for (int i = 0; i < 8; i++) pushSlot((i != 0), 1'b0, 1'b1, 1'b0, (i == 0));
    end
    for (int i = 0; i < 4; i++) pushSlot(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // abortAt/rstAt/midEn: 0 = none, -1 = random cycle inside the frame.
  task automatic runFrame(input string name, input logic [7:0] sizeField, input logic [7:0] pay[$],
                          input int abortAt, input int abortHold, input int rstAt, input int midEn);
    int lastValid;
    int ab;
    int rs;
    int me;
    bit eTx, eV, eD, eR, eA;
    buildModel(sizeField, pay, 0, lastValid);
    ab = (abortAt < 0) ? int'($urandom_range(1, lastValid)) : abortAt;
    rs = (rstAt < 0) ? int'($urandom_range(1, lastValid)) : rstAt;
    me = (midEn < 0) ? int'($urandom_range(1, lastValid)) : midEn;
    buildModel(sizeField, pay, ab, lastValid);
    bufQ = pay;
    obsTx.delete();
    txIf.Tx_FrameSize = sizeField;
    for (int k = 0; k < selQ.size(); k++) begin
      if (rs > 0 && k > rs) begin
        eTx = 1'b1; eV = 1'b0; eD = 1'b1; eR = 1'b0; eA = 1'b0;
      end else begin
        eTx = (k == 0) ? 1'b1 : selQ[k-1];
        eV = validQ[k]; eD = doneQ[k]; eR = rdQ[k]; eA = abQ[k];
      end
      checkEq($sformatf("%s tx c%0d", name, k), txIf.Tx, eTx);
      checkEq($sformatf("%s valid c%0d", name, k), txIf.Tx_ValidFrame, eV);
      checkEq($sformatf("%s done c%0d", name, k), txIf.Tx_Done, eD);
      checkEq($sformatf("%s rdbuff c%0d", name, k), txIf.Tx_RdBuff, eR);
      checkEq($sformatf("%s aborted c%0d", name, k), txIf.Tx_AbortedTrans, eA);
      obsTx.push_back(txIf.Tx);
      if (txIf.Tx_RdBuff && bufQ.size() > 0) txIf.Tx_DataOutBuff = bufQ.pop_front();
      txIf.Tx_Enable = (k == 0) || (me > 0 && k == me);
      txIf.Tx_AbortFrame = (ab > 0) && (k >= ab) && (k < ab + abortHold);
      Rst = !(rs > 0 && k == rs);
      if (k == 1) txIf.Tx_FrameSize = 8'($urandom);
      @(negedge Clk);
    end
    txIf.Tx_Enable = 1'b0;
    txIf.Tx_AbortFrame = 1'b0;
    Rst = 1'b1;
  endtask

  task automatic checkIdle(input string name, input int cycles, input bit noise);
    for (int k = 0; k < cycles; k++) begin
      checkEq($sformatf("%s tx c%0d", name, k), txIf.Tx, 1);
      checkEq($sformatf("%s valid c%0d", name, k), txIf.Tx_ValidFrame, 0);
      checkEq($sformatf("%s done c%0d", name, k), txIf.Tx_Done, 1);
      checkEq($sformatf("%s rdbuff c%0d", name, k), txIf.Tx_RdBuff, 0);
      checkEq($sformatf("%s aborted c%0d", name, k), txIf.Tx_AbortedTrans, 0);
      txIf.Tx_Enable = 1'b0;
      txIf.Tx_AbortFrame = noise ? 1'($urandom) : 1'b0;
      txIf.Tx_FrameSize = noise ? 8'($urandom) : 8'd0;
      @(negedge Clk);
    end
    txIf.Tx_AbortFrame = 1'b0;
  endtask

  initial begin
    logic [7:0] pay[$];
    string exp7e;
    int n;
    int mode;
    Rst = 1'b0;
    txIf.Tx_Enable = 1'b0;
    txIf.Tx_AbortFrame = 1'b0;
    txIf.Tx_FrameSize = 8'd0;
    txIf.Tx_DataOutBuff = 8'd0;
    repeat (3) @(negedge Clk);
    checkEq("reset tx", txIf.Tx, 1);
    checkEq("reset valid", txIf.Tx_ValidFrame, 0);
    checkEq("reset done", txIf.Tx_Done, 1);
    checkEq("reset rdbuff", txIf.Tx_RdBuff, 0);
    checkEq("reset aborted", txIf.Tx_AbortedTrans, 0);
    Rst = 1'b1;
    @(negedge Clk);

    checkIdle("idle", 50, 1'b1);

    // Zero-length request must be ignored.
    txIf.Tx_FrameSize = 8'd0;
    txIf.Tx_Enable = 1'b1;
    @(negedge Clk);
    txIf.Tx_Enable = 1'b0;
    checkIdle("size0", 12, 1'b0);

    pay = '{8'h7E};
    runFrame("byte7e", 8'd1, pay, 0, 0, 0, 0);
`ifndef TX_FCS_EN
    exp7e = "0111111001111101001111110";
    for (int i = 0; i < exp7e.len(); i++)
      checkEq($sformatf("byte7e line bit %0d", i), obsTx[2+i], (exp7e[i] == 8'h31));
    checkEq("byte7e line idle after", obsTx[2+exp7e.len()], 1);
`endif

    pay = '{8'h01, 8'h02};
    runFrame("fcs0102", 8'd2, pay, 0, 0, 0, 0);

    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'(i));
    runFrame("abort3rd", 8'd10, pay, 28, 5, 0, 0);

    pay = '{8'hFF, 8'hA5, 8'h3C};
    runFrame("midenable", 8'd3, pay, 0, 0, 0, 15);

    pay = '{8'hFF, 8'hFF, 8'h55, 8'h0F};
    runFrame("rstdata", 8'd4, pay, 0, 0, 14, 0);
    pay = '{8'h12, 8'hFF};
    runFrame("afterrst", 8'd2, pay, 0, 0, 0, 0);

    pay.delete();
    for (int i = 0; i < MAX_FRAME; i++) pay.push_back(8'($urandom));
    runFrame("clamp", 8'd200, pay, 0, 0, 0, 0);

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 6);
      pay.delete();
      for (int i = 0; i < n; i++)
        pay.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      mode = $urandom_range(0, 3);
      case (mode)
        1:       runFrame($sformatf("rand%0d", f), 8'(n), pay, -1, $urandom_range(1, 10), 0, 0);
        2:       runFrame($sformatf("rand%0d", f), 8'(n), pay, 0, 0, -1, 0);
        3:       runFrame($sformatf("rand%0d", f), 8'(n), pay, 0, 0, 0, -1);
        default: runFrame($sformatf("rand%0d", f), 8'(n), pay, 0, 0, 0, 0);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
